// File: rtl/osd_ram_writer.sv
// ----------------------------------------------------------------------------
// osd_ram_writer
//
// Command-driven writer and round-robin arbiter for the OSD character RAM
// write port. Two requesters (port 0: JVS status/debug printer, port 1:
// host/APF command path) submit high-level commands. Each command becomes a
// stream of single-cycle RAM writes at linear address row*COLS+col.
// Ops: 0=PUTC, 1=FILL, 2=HEX, 3=CLEAR.
//
// Ports:
//   clk, reset           system clock, synchronous active-high reset
//   vblank               vertical blank; gates writes only with OSD_VBLANK_WR_EN
//   req_valid/req_ready  per-requester command handshake (index = port)
//   req_op/col/row/data/len  packed per-requester command fields
//   done, err            one-cycle completion / rejection pulse to the owner
//   busy                 high in CHECK, WRITE and DONE
//   wr_addr/wr_data/wr_en  character RAM write port
//
// Handshake: a command is accepted on the cycle where req_valid[n] and
// req_ready[n] are both high. req_ready is only ever high in IDLE and only
// for the granted requester; fields are sampled solely on that cycle, and
// req_valid may be withdrawn before acceptance without side effects.
//
// Optional build macro: OSD_VBLANK_WR_EN -- when defined, writes in WRITE
// issue only while vblank is high; address and count hold while it is low.
// ----------------------------------------------------------------------------
module osd_ram_writer #(
   parameter int COLS   = 40,
   parameter int ROWS   = 30,
   parameter int ADDR_W = 11
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              vblank,
   input  logic [1:0]        req_valid,
   output logic [1:0]        req_ready,
   input  logic [3:0]        req_op,
   input  logic [11:0]       req_col,
   input  logic [9:0]        req_row,
   input  logic [15:0]       req_data,
   input  logic [13:0]       req_len,
   output logic [1:0]        done,
   output logic [1:0]        err,
   output logic              busy,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [7:0]        wr_data,
   output logic              wr_en
);

   localparam int TOTAL = COLS * ROWS;
   localparam int CNT_W = ADDR_W + 1;

   localparam logic [1:0] OP_PUTC  = 2'd0;
   localparam logic [1:0] OP_FILL  = 2'd1;
   localparam logic [1:0] OP_HEX   = 2'd2;
   localparam logic [1:0] OP_CLEAR = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CHECK = 2'd1,
      S_WRITE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   // FSM state register, kept as a plain named enum for checker binding.
   state_t             state;
   logic               last_grant;
   logic               owner;
   logic [1:0]         op_q;
   logic [5:0]         col_q;
   logic [4:0]         row_q;
   logic [7:0]         data_q;
   logic [6:0]         len_q;
   logic [CNT_W-1:0]   remain;
   logic               wr_pend;

   logic               gnt_any;
   logic               gnt_idx;
   logic               advance;
   logic               pos_bad;
   logic [ADDR_W-1:0]  start_addr;
   logic [ADDR_W-1:0]  next_addr;
   logic [CNT_W-1:0]   first_count;
   logic [7:0]         first_data;
   logic [7:0]         next_data;
   logic [1:0]         owner_mask;

   function automatic logic [7:0] hex_char(input logic [3:0] n);
      // 0-9 -> '0'..'9', A-F -> 'A'..'F' (8'h41 - 10 = 8'h37)
      return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
   endfunction

   // Grant: a lone requester wins; on contention the one not served last wins.
   always_comb begin
      gnt_any = |req_valid;
      gnt_idx = 1'b0;
      if (req_valid == 2'b11)
         gnt_idx = ~last_grant;
      else if (req_valid[1])
         gnt_idx = 1'b1;
   end

   assign req_ready = (state == S_IDLE && gnt_any && !reset)
                      ? (gnt_idx ? 2'b10 : 2'b01) : 2'b00;

   assign owner_mask = owner ? 2'b10 : 2'b01;

   assign pos_bad    = (32'(col_q) >= COLS) || (32'(row_q) >= ROWS);
   assign start_addr = ADDR_W'(32'(row_q) * COLS + 32'(col_q));

   always_comb begin
      first_count = CNT_W'(1);
      case (op_q)
         OP_FILL:  first_count = (len_q == 7'd0) ? CNT_W'(1) : CNT_W'(len_q);
         OP_HEX:   first_count = CNT_W'(2);
         OP_CLEAR: first_count = CNT_W'(TOTAL);
         default:  first_count = CNT_W'(1);
      endcase
   end

   // HEX prints the high nibble first; every later write of a HEX command is
   // the low nibble. All other ops repeat the latched code.
   assign first_data = (op_q == OP_HEX) ? hex_char(data_q[7:4]) : data_q;
   assign next_data  = (op_q == OP_HEX) ? hex_char(data_q[3:0]) : data_q;

   // Linear address wraps at the end of the screen, never beyond it.
   assign next_addr = (wr_addr == ADDR_W'(TOTAL - 1)) ? '0 : wr_addr + ADDR_W'(1);

`ifdef OSD_VBLANK_WR_EN
   // The pending write is presented only while vblank is high and advances
   // only then; while vblank is low the address/count simply hold.
   assign advance = vblank;
   assign wr_en   = wr_pend & vblank;
`else
   logic vblank_unused;
   assign vblank_unused = vblank;
   assign advance       = 1'b1;
   assign wr_en         = wr_pend;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         last_grant <= 1'b1;
         owner      <= 1'b0;
         op_q       <= '0;
         col_q      <= '0;
         row_q      <= '0;
         data_q     <= '0;
         len_q      <= '0;
         remain     <= '0;
         wr_pend    <= 1'b0;
         wr_addr    <= '0;
         wr_data    <= '0;
         done       <= '0;
         err        <= '0;
         busy       <= 1'b0;
      end else begin
         done <= '0;
         err  <= '0;
         case (state)
            S_IDLE: begin
               if (|(req_valid & req_ready)) begin
                  owner      <= gnt_idx;
                  last_grant <= gnt_idx;
                  op_q       <= gnt_idx ? req_op[3:2]    : req_op[1:0];
                  col_q      <= gnt_idx ? req_col[11:6]  : req_col[5:0];
                  row_q      <= gnt_idx ? req_row[9:5]   : req_row[4:0];
                  data_q     <= gnt_idx ? req_data[15:8] : req_data[7:0];
                  len_q      <= gnt_idx ? req_len[13:7]  : req_len[6:0];
                  busy       <= 1'b1;
                  state      <= S_CHECK;
               end
            end
            S_CHECK: begin
               if (op_q != OP_CLEAR && pos_bad) begin
                  err   <= owner_mask;
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end else begin
                  wr_pend <= 1'b1;
                  wr_addr <= (op_q == OP_CLEAR) ? '0 : start_addr;
                  wr_data <= first_data;
                  remain  <= first_count - CNT_W'(1);
                  state   <= S_WRITE;
               end
            end
            S_WRITE: begin
               // remain counts writes still to issue after the presented one.
               if (advance) begin
                  if (remain == '0) begin
                     wr_pend <= 1'b0;
                     done    <= owner_mask;
                     state   <= S_DONE;
                  end else begin
                     wr_addr <= next_addr;
                     wr_data <= next_data;
                     remain  <= remain - CNT_W'(1);
                  end
               end
            end
            S_DONE: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_osd_ram_writer.sv
// ----------------------------------------------------------------------------
// tb_osd_ram_writer
//
// Directed bench for osd_ram_writer: reset state, PUTC timing, HEX encoding,
// FILL across rows and screen wrap, position errors, round-robin grants,
// CLEAR, reset during CLEAR, and (with OSD_VBLANK_WR_EN) vblank gating.
// Expected writes are pushed into exp_q and compared by a write monitor.
// ----------------------------------------------------------------------------
module tb_osd_ram_writer;

   localparam int COLS   = 40;
   localparam int ROWS   = 30;
   localparam int ADDR_W = 11;
   localparam int TOTAL  = COLS * ROWS;

   localparam logic [1:0] OP_PUTC  = 2'd0;
   localparam logic [1:0] OP_FILL  = 2'd1;
   localparam logic [1:0] OP_HEX   = 2'd2;
   localparam logic [1:0] OP_CLEAR = 2'd3;

   // ---------------- clock / reset ----------------
   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              vblank = 1'b0;
   logic [1:0]        req_valid = '0;
   logic [1:0]        req_ready;
   logic [3:0]        req_op = '0;
   logic [11:0]       req_col = '0;
   logic [9:0]        req_row = '0;
   logic [15:0]       req_data = '0;
   logic [13:0]       req_len = '0;
   logic [1:0]        done;
   logic [1:0]        err;
   logic              busy;
   logic [ADDR_W-1:0] wr_addr;
   logic [7:0]        wr_data;
   logic              wr_en;

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   osd_ram_writer #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .vblank    (vblank),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_col   (req_col),
      .req_row   (req_row),
      .req_data  (req_data),
      .req_len   (req_len),
      .done      (done),
      .err       (err),
      .busy      (busy),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .wr_en     (wr_en)
   );

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_fail   = 0;
   logic [18:0] exp_q[$];
   int wr_count = 0;
   int first_wr = 0;
   int last_wr  = 0;
   int done_cnt[2];
   int err_cnt[2];
   logic [18:0] mon_e;
   logic vb_en = 1'b0;
   int vb_ph = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic clr_stats();
      exp_q.delete();
      wr_count = 0;
      done_cnt[0] = 0; done_cnt[1] = 0;
      err_cnt[0]  = 0; err_cnt[1]  = 0;
   endtask

   task automatic push_exp(input int addr, input logic [7:0] data);
      exp_q.push_back({ADDR_W'(addr), data});
   endtask

   // Write/pulse monitor, sampling on the inactive edge.
   always @(negedge clk) begin
      if (wr_en) begin
         if (exp_q.size() == 0) begin
            check("wr_unexpected", 32'(wr_en), 32'(0));
         end else begin
            mon_e = exp_q.pop_front();
            check("wr_addr_data", {13'b0, wr_addr, wr_data}, {13'b0, mon_e});
         end
`ifdef OSD_VBLANK_WR_EN
         if (vb_en) check("wr_in_vblank", 32'(vblank), 32'(1));
`endif
         if (wr_count == 0) first_wr = cyc;
         last_wr = cyc;
         wr_count++;
      end
      for (int p = 0; p < 2; p++) begin
         if (done[p]) done_cnt[p]++;
         if (err[p])  err_cnt[p]++;
      end
   end

   // vblank toggles every 2 cycles, changed well away from both edges.
   always @(posedge clk) begin
      #2;
      if (vb_en) begin
         vb_ph = vb_ph + 1;
         vblank = vb_ph[1];
      end
   end

   // ---------------- driver tasks ----------------
   task automatic set_fields(input int p, input logic [1:0] op, input int col, input int row,
                             input logic [7:0] data, input logic [6:0] len);
      req_op[p*2 +: 2]   = op;
      req_col[p*6 +: 6]  = 6'(col);
      req_row[p*5 +: 5]  = 5'(row);
      req_data[p*8 +: 8] = data;
      req_len[p*7 +: 7]  = len;
   endtask

   // Returns the cycle N in which the command was accepted (-1 on timeout).
   task automatic issue(input int p, input logic [1:0] op, input int col, input int row,
                        input logic [7:0] data, input logic [6:0] len, output int acc);
      @(negedge clk);
      set_fields(p, op, col, row, data, len);
      req_valid[p] = 1'b1;
      acc = -1;
      for (int i = 0; i < 50; i++) begin
         #1;
         if (req_ready[p]) begin
            acc = cyc;
            break;
         end
         @(negedge clk);
      end
      if (acc < 0) check("accept_timeout", 32'(req_ready[p]), 32'(1));
      @(posedge clk);
      #1;
      req_valid[p] = 1'b0;
   endtask

   task automatic wait_done(input int p, input int max, output int dc);
      dc = -1;
      for (int i = 0; i < max; i++) begin
         @(negedge clk);
         if (done[p]) begin
            dc = cyc;
            break;
         end
      end
      if (dc < 0) check("done_timeout", 32'(done[p]), 32'(1));
      @(negedge clk);
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // ---------------- stimulus ----------------
   int acc, dc, acc2;
   int gseq[$];
   int aseq[$];

   initial begin
      done_cnt[0] = 0; done_cnt[1] = 0;
      err_cnt[0]  = 0; err_cnt[1]  = 0;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_wr_en",     32'(wr_en),     0);
      check("rst_wr_addr",   32'(wr_addr),   0);
      check("rst_wr_data",   32'(wr_data),   0);
      check("rst_done",      32'(done),      0);
      check("rst_err",       32'(err),       0);
      check("rst_busy",      32'(busy),      0);
      check("rst_req_ready", 32'(req_ready), 0);
      reset = 1'b0;
      idle_cycles(2);

      // PUTC port 0, row 2 col 5 -> addr 85, strobe at N+2, done at N+3
      clr_stats();
      push_exp(85, 8'h41);
      issue(0, OP_PUTC, 5, 2, 8'h41, 7'd0, acc);
      wait_done(0, 20, dc);
      check("putc_first_wr_cyc", 32'(first_wr), 32'(acc + 2));
      check("putc_done_cyc",     32'(dc),       32'(acc + 3));
      check("putc_wr_count",     32'(wr_count), 1);
      check("putc_done_other",   32'(done_cnt[1]), 0);
      check("putc_busy_after",   32'(busy),     0);

      // HEX port 1, 8'h3C at (0,0) -> '3' then 'C'
      clr_stats();
      push_exp(0, 8'h33);
      push_exp(1, 8'h43);
      issue(1, OP_HEX, 0, 0, 8'h3C, 7'd0, acc);
      wait_done(1, 20, dc);
      check("hex3c_count", 32'(wr_count), 2);
      check("hex3c_done1", 32'(done_cnt[1]), 1);
      check("hex3c_done_cyc", 32'(dc), 32'(acc + 4));

      // HEX with letter high nibble: 8'hA9 at (1,0) -> 'A','9' at 40,41
      clr_stats();
      push_exp(40, 8'h41);
      push_exp(41, 8'h39);
      issue(0, OP_HEX, 0, 1, 8'hA9, 7'd0, acc);
      wait_done(0, 20, dc);
      check("hexa9_count", 32'(wr_count), 2);

      // FILL across a row boundary: 38,39,40,41 back to back
      clr_stats();
      for (int a = 38; a < 42; a++) push_exp(a, 8'h2D);
      issue(0, OP_FILL, 38, 0, 8'h2D, 7'd4, acc);
      wait_done(0, 20, dc);
      check("fill_row_count",  32'(wr_count), 4);
      check("fill_row_span",   32'(last_wr - first_wr), 3);
      check("fill_row_done",   32'(dc), 32'(acc + 6));

      // FILL off the end of the screen wraps: 1199, 0, 1
      clr_stats();
      push_exp(1199, 8'h2A);
      push_exp(0,    8'h2A);
      push_exp(1,    8'h2A);
      issue(1, OP_FILL, 39, 29, 8'h2A, 7'd3, acc);
      wait_done(1, 20, dc);
      check("fill_wrap_count", 32'(wr_count), 3);
      check("fill_wrap_left",  32'(exp_q.size()), 0);

      // FILL len 0 behaves as len 1
      clr_stats();
      push_exp(200, 8'h2E);
      issue(1, OP_FILL, 0, 5, 8'h2E, 7'd0, acc);
      wait_done(1, 20, dc);
      check("fill_len0_count", 32'(wr_count), 1);

      // Position errors: col 40 (port 0), row 30 (port 1)
      clr_stats();
      issue(0, OP_PUTC, 40, 0, 8'h41, 7'd0, acc);
      idle_cycles(5);
      issue(1, OP_FILL, 0, 30, 8'h41, 7'd5, acc);
      idle_cycles(5);
      check("err_col_pulse",  32'(err_cnt[0]), 1);
      check("err_row_pulse",  32'(err_cnt[1]), 1);
      check("err_no_writes",  32'(wr_count), 0);
      check("err_no_done",    32'(done_cnt[0] + done_cnt[1]), 0);

      // Both valid: port 0 wins first after reset, then alternate
      reset = 1'b1;
      idle_cycles(2);
      reset = 1'b0;
      clr_stats();
      push_exp(40, 8'h61);
      push_exp(41, 8'h62);
      push_exp(40, 8'h61);
      set_fields(0, OP_PUTC, 0, 1, 8'h61, 7'd0);
      set_fields(1, OP_PUTC, 1, 1, 8'h62, 7'd0);
      req_valid = 2'b11;
      for (int i = 0; i < 60; i++) begin
         #1;
         if (req_ready != 2'b00) begin
            gseq.push_back(req_ready[1] ? 1 : 0);
            aseq.push_back(cyc);
            if (gseq.size() == 3) break;
         end
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      req_valid = 2'b00;
      check("arb_grants", 32'(gseq.size()), 3);
      if (gseq.size() == 3) begin
         check("arb_first",  32'(gseq[0]), 0);
         check("arb_second", 32'(gseq[1]), 1);
         check("arb_third",  32'(gseq[2]), 0);
         acc2 = aseq[1] - aseq[0];
         check("arb_throughput", 32'(acc2), 4);
      end
      idle_cycles(10);
      check("arb_done0", 32'(done_cnt[0]), 2);
      check("arb_done1", 32'(done_cnt[1]), 1);
      check("arb_left",  32'(exp_q.size()), 0);

      // CLEAR: 1200 writes 0..1199, col/row ignored
      clr_stats();
      for (int a = 0; a < TOTAL; a++) push_exp(a, 8'h20);
      issue(1, OP_CLEAR, 63, 31, 8'h20, 7'd0, acc);
      wait_done(1, 1300, dc);
      check("clear_count",    32'(wr_count), 32'(TOTAL));
      check("clear_done_cyc", 32'(dc), 32'(acc + TOTAL + 2));
      check("clear_left",     32'(exp_q.size()), 0);

      // Reset during CLEAR at write 100: writes stop, no done
      clr_stats();
      for (int a = 0; a < 100; a++) push_exp(a, 8'h00);
      issue(0, OP_CLEAR, 0, 0, 8'h00, 7'd0, acc);
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         #1;
         if (wr_count == 100) break;
      end
      check("rstmid_reached", 32'(wr_count), 100);
      reset = 1'b1;
      @(negedge clk);
      check("rstmid_wr_en",  32'(wr_en), 0);
      check("rstmid_busy",   32'(busy), 0);
      check("rstmid_addr",   32'(wr_addr), 0);
      @(negedge clk);
      reset = 1'b0;
      idle_cycles(20);
      check("rstmid_count",  32'(wr_count), 100);
      check("rstmid_done",   32'(done_cnt[0] + done_cnt[1]), 0);
      check("rstmid_err",    32'(err_cnt[0] + err_cnt[1]), 0);

`ifdef OSD_VBLANK_WR_EN
      // FILL len 4 with vblank toggling: 4 writes, only while vblank high
      clr_stats();
      for (int a = 130; a < 134; a++) push_exp(a, 8'h55);
      vb_en = 1'b1;
      issue(0, OP_FILL, 10, 3, 8'h55, 7'd4, acc);
      wait_done(0, 60, dc);
      vb_en = 1'b0;
      vblank = 1'b0;
      check("vb_count", 32'(wr_count), 4);
      check("vb_left",  32'(exp_q.size()), 0);
`endif

      idle_cycles(2);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Global watchdog
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1);
   end

endmodule
